// File: rtl/deserializer.sv
// Word-to-frame deserializer: gathers MAX_COUNT serial words into one parallel
// frame and holds it under a valid/ready handshake until the consumer takes it.
module deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_COUNT  = 20,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_valid,
  input  logic [DATA_WIDTH-1:0]                serial_in,
  output logic                                 o_ready,
  input  logic                                 i_flush,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [MAX_COUNT-1:0][DATA_WIDTH-1:0] parallel_out,
  output logic [CW-1:0]                        o_count,
  output logic                                 o_overflow
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_COUNT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_COUNT);

  state_t          state, next_state;
  logic [CW-1:0]   count, next_count;
  logic            accept;
  logic            wr_en;
  logic [CW-1:0]   wr_idx;

  assign o_valid = (state == FULL);
  assign o_count = count;

  always_comb begin
    next_state = state;
    next_count = count;
    wr_en      = 1'b0;
    wr_idx     = '0;
    o_ready    = 1'b0;
    if (!rst) o_ready = (state == FILL) ? 1'b1 : i_ready;
    accept = i_valid && o_ready;
    case (state)
      FILL: begin
        // A flush wins over a word presented in the same cycle.
        if (i_flush) begin
          next_count = '0;
        end else if (accept) begin
          wr_en  = 1'b1;
          wr_idx = count;
          if (count == LAST_IDX) begin
            next_state = FULL;
            next_count = FULL_CNT;
          end else begin
            next_count = count + 1'b1;
          end
        end
      end
      FULL: begin
        if (i_ready) begin
          if (accept) begin
            // Consume and start the next frame in one edge; a one-word frame
            // is already complete, so it stays in FULL.
            wr_en      = 1'b1;
            wr_idx     = '0;
            next_count = CW'(1);
            next_state = (MAX_COUNT == 1) ? FULL : FILL;
          end else begin
            next_count = '0;
            next_state = FILL;
          end
        end
      end
      default: begin
        next_state = FILL;
        next_count = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      count        <= '0;
      parallel_out <= '0;
      o_overflow   <= 1'b0;
    end else begin
      state      <= next_state;
      count      <= next_count;
      o_overflow <= i_valid && !o_ready;
      for (int i = 0; i < MAX_COUNT; i++) begin
        if (wr_en && (wr_idx == CW'(i))) parallel_out[i] <= serial_in;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer at DATA_WIDTH=8, MAX_COUNT=4; expected
// frames and counts are hand-derived constants.
module tb_deserializer;
  localparam int DW = 8;
  localparam int MC = 4;
  localparam int CW = $clog2(MC + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_valid;
  logic [DW-1:0]          serial_in;
  logic                   o_ready;
  logic                   i_flush;
  logic                   o_valid;
  logic                   i_ready;
  logic [MC-1:0][DW-1:0]  parallel_out;
  logic [CW-1:0]          o_count;
  logic                   o_overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  deserializer #(.DATA_WIDTH(DW), .MAX_COUNT(MC)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .serial_in(serial_in),
    .o_ready(o_ready), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .parallel_out(parallel_out), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; serial_in = '0; i_flush = 1'b0; i_ready = 1'b0;
    step(); step();
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", o_ready); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", o_valid); end
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
    n_cmp++; if (parallel_out !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", parallel_out); end
    n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", o_overflow); end
    rst = 1'b0;
    #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready got %0b want 1", o_ready); end
  endtask

  task automatic test_basic_frame();
    logic [7:0] words [4];
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; serial_in = words[k];
      step();
      if (k == 2) begin
        n_cmp++; if (o_valid !== 1'b0 || o_count !== 3'd3) begin n_fail++; $display("FAIL basic_partial valid %0b count %0d want 0/3", o_valid, o_count); end
      end
    end
    i_valid = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", o_valid); end
    n_cmp++; if (parallel_out !== 32'h44332211) begin n_fail++; $display("FAIL basic_data got %h want 44332211", parallel_out); end
    n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL basic_count got %0d want 4", o_count); end
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready got %0b want 0", o_ready); end
  endtask

  task automatic test_overflow();
    i_ready = 1'b0; i_valid = 1'b1; serial_in = 8'h55;
    step();
    i_valid = 1'b0;
    n_cmp++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %0b want 1", o_overflow); end
    n_cmp++; if (parallel_out !== 32'h44332211 || o_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_frame got %h/%0b want 44332211/1", parallel_out, o_valid); end
    step();
    n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_single got %0b want 0", o_overflow); end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    n_cmp++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin n_fail++; $display("FAIL consume valid %0b count %0d want 0/0", o_valid, o_count); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp;
    i_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      i_valid = 1'b1; serial_in = 8'(k);
      #1;
      n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_stall word %0d ready %0b want 1", k, o_ready); end
      step();
      n_cmp++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL stream_ovf word %0d got %0b want 0", k, o_overflow); end
      if (k % 4 == 0) begin
        exp = {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)};
        n_cmp++; if (o_valid !== 1'b1 || parallel_out !== exp || o_count !== 3'd4) begin n_fail++; $display("FAIL stream_frame word %0d got %0b/%h/%0d want 1/%h/4", k, o_valid, parallel_out, o_count, exp); end
      end else begin
        n_cmp++; if (o_valid !== 1'b0 || o_count !== 3'(k % 4)) begin n_fail++; $display("FAIL stream_fill word %0d got %0b/%0d want 0/%0d", k, o_valid, o_count, k % 4); end
      end
    end
    i_valid = 1'b0;
    step();
    i_ready = 1'b0;
    n_cmp++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin n_fail++; $display("FAIL stream_end got %0b/%0d want 0/0", o_valid, o_count); end
  endtask

  task automatic test_simultaneous();
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; serial_in = 8'(8'hB0 + k);
      step();
    end
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b1 || parallel_out !== 32'hB3B2B1B0) begin n_fail++; $display("FAIL simul_full got %0b/%h want 1/b3b2b1b0", o_valid, parallel_out); end
    i_ready = 1'b1; i_valid = 1'b1; serial_in = 8'hA0;
    step();
    i_ready = 1'b0; i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b0 || o_count !== 3'd1) begin n_fail++; $display("FAIL simul_state got %0b/%0d want 0/1", o_valid, o_count); end
    n_cmp++; if (parallel_out[0] !== 8'hA0) begin n_fail++; $display("FAIL simul_elem0 got %h want a0", parallel_out[0]); end
  endtask

  task automatic test_flush();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL flush_idle got %0d want 0", o_count); end
    i_valid = 1'b1; serial_in = 8'h01; step();
    serial_in = 8'h02; step();
    n_cmp++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL flush_pre got %0d want 2", o_count); end
    serial_in = 8'h03; i_flush = 1'b1; step();
    i_flush = 1'b0; i_valid = 1'b0;
    n_cmp++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %0d/%0b want 0/0", o_count, o_valid); end
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; serial_in = 8'(8'h10 + k);
      step();
    end
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b1 || parallel_out !== 32'h13121110) begin n_fail++; $display("FAIL flush_frame got %0b/%h want 1/13121110", o_valid, parallel_out); end
    i_flush = 1'b1; step();
    i_flush = 1'b0;
    n_cmp++; if (o_valid !== 1'b1 || parallel_out !== 32'h13121110 || o_count !== 3'd4) begin n_fail++; $display("FAIL flush_full got %0b/%h/%0d want 1/13121110/4", o_valid, parallel_out, o_count); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (o_valid !== 1'b0 || o_count !== 3'd0 || parallel_out !== 32'h0) begin n_fail++; $display("FAIL rst_full got %0b/%0d/%h want 0/0/0", o_valid, o_count, parallel_out); end
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; serial_in = 8'(8'h21 + k);
      step();
    end
    i_valid = 1'b0;
    n_cmp++; if (o_count !== 3'd3 || parallel_out[2:0] !== 24'h232221) begin n_fail++; $display("FAIL rst_prefill got %0d/%h want 3/232221", o_count, parallel_out[2:0]); end
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (o_valid !== 1'b0 || o_count !== 3'd0 || parallel_out !== 32'h0) begin n_fail++; $display("FAIL rst_partial got %0b/%0d/%h want 0/0/0", o_valid, o_count, parallel_out); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_streaming();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/deserializer.md
# deserializer

Collects a stream of DATA_WIDTH words, one per valid cycle, into a MAX_COUNT-element parallel frame and presents it to the consumer under a valid/ready handshake. It is the receive-side counterpart of the core's word serializer. It rebuilds layer-output vectors for the next stage of the MNIST datapath, for example a serialized neuron output that feeds a parallel matrix-vector unit. Framing is implicit: every MAX_COUNT accepted words form one frame.

## Interface
- DATA_WIDTH, 32, width of each word
- MAX_COUNT, 20, words per frame (≥1)
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- i_valid  in  1  serial_in carries a word this cycle
- serial_in  in  DATA_WIDTH  input word
- o_ready  out  1  block accepts a word this cycle (combinational from state and i_ready)
- i_flush  in  1  discard the partially filled frame
- o_valid  out  1  parallel_out holds a complete frame
- i_ready  in  1  consumer takes the frame this cycle
- parallel_out  out  DATA_WIDTH × MAX_COUNT  frame; element 0 = first word received
- o_count  out  $clog2(MAX_COUNT+1)  words currently held, range 0..MAX_COUNT
- o_overflow  out  1  registered one-cycle pulse: a word was presented while o_ready=0 and was dropped

## Operation
- Two states: FILL and FULL. Reset enters FILL.
- Reset values: count 0, o_valid 0, all parallel_out elements 0, o_overflow 0. While rst=1, o_ready=0.
- A word is accepted on a cycle when i_valid && o_ready. It is written to parallel_out[count], and count increments by 1.
- **FILL:**
  - o_ready=1 and o_valid=0.
  - When the accepted word is at index MAX_COUNT-1, the block moves to FULL and count becomes MAX_COUNT.
- **FULL:**
  - o_valid=1, o_count=MAX_COUNT, and parallel_out is frozen.
  - o_ready = i_ready.
  - The frame is consumed when i_ready=1, and the block returns to FILL with count 0.
  - If consume and accept happen in the same cycle (i_ready && i_valid), the word is written to index 0 and count becomes 1. Exception: when MAX_COUNT=1, the block stays in FULL with the new frame.
- **i_flush:**
  - In FILL, count goes to 0. Any word presented in the same cycle is discarded, even though the handshake completed. parallel_out contents are not cleared.
  - In FULL, i_flush is ignored and the complete frame is preserved.
- Stale elements at index ≥ count in FILL are don't-care for the consumer.
- **o_overflow:** registered (i_valid && !o_ready && !rst). It exists because upstream serializers do not honour ready.
- Stall tolerance: any number of idle cycles between words is allowed. Partial state holds indefinitely.

## Timing
- Acceptance edge N writes the element and the count. Both are visible in cycle N+1.
- Last-word latency: o_valid rises 1 cycle after the edge that accepts word MAX_COUNT-1.
- Back-to-back frames with i_ready tied high give full throughput: MAX_COUNT words per MAX_COUNT cycles with no bubble.
- o_valid is held high, with parallel_out stable, until the edge where i_ready=1. It drops in the following cycle unless MAX_COUNT=1 and a word was accepted on that edge.
- Reset asserted mid-frame or mid-FULL applies all reset values on the next edge, and the frame is lost.
- o_overflow goes high one cycle after the dropped word, for one cycle per dropped word.

## Test plan
- **Basic frame** (DATA_WIDTH=8, MAX_COUNT=4): drive 0x11, 0x22, 0x33, 0x44 on consecutive cycles with i_ready=0.
  - o_valid rises in the cycle after 0x44 is accepted.
  - parallel_out = {0x11, 0x22, 0x33, 0x44}, o_count=4, o_ready=0.
- **Backpressure and overflow:** in FULL, present 0x55 with i_ready=0.
  - o_overflow pulses once and the frame is unchanged.
  - Then raise i_ready: o_valid drops next cycle and o_count=0.
- **Streaming:** i_ready=1, 12 consecutive words 1..12.
  - o_valid pulses for 1 cycle at each of the 3 frames: {1,2,3,4}, {5,6,7,8}, {9,10,11,12}.
  - No o_overflow and no stall cycles.
- **Simultaneous consume+accept:** in FULL, assert i_ready with word 0xA0 present.
  - Next cycle o_valid=0, o_count=1, parallel_out[0]=0xA0.
- **Flush:**
  - Accept 0x01 and 0x02, then assert i_flush together with 0x03: o_count=0.
  - Next 4 words 0x10..0x13 produce a frame of {0x10..0x13}.
  - i_flush asserted in FULL leaves o_valid=1 and the data intact.
- **Reset mid-operation:**
  - Assert rst with o_count=3: next cycle o_count=0, o_valid=0, all parallel_out elements 0.
  - Assert rst in FULL: o_valid clears on the next edge.
